// File: rtl/mmio_bus_bridge.sv
// Data-side bridge: decodes core accesses to RAM, a GPIO/timer register bank or
// unmapped space, and returns read data from all targets with one-cycle latency.
module mmio_bus_bridge #(
    parameter int          RAM_AW      = 10,
    parameter int          GPIO_W      = 8,
    parameter logic [3:0]  PERIPH_BASE = 4'h4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       daddr,
    input  logic [31:0]       ddata_w,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       ddata_r,
    output logic [RAM_AW-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              ram_wread,
    input  logic [31:0]       ram_q,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        SEL_RAM    = 2'd0,
        SEL_PERIPH = 2'd1,
        SEL_ZERO   = 2'd2
    } sel_e;

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_CNT      = 3'd2;
    localparam logic [2:0] OFF_CMP      = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    sel_e              sel_q, sel_d;
    logic [31:0]       prdata_q, prdata_d;
    logic              err_q, err_d;
    logic [GPIO_W-1:0] gpio_q, gpio_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       cmp_q, cmp_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              match_q, match_d;

    logic        hit_ram, hit_per, aligned, access, acc_ok, acc_err;
    logic        rd_only, per_wr, tmr_match;
    logic [2:0]  off;
    logic [31:0] per_rdata;

    // Address decode; an erroring access is blocked from every target.
    always_comb begin
        hit_ram = (daddr[31:28] == 4'h0);
        hit_per = (daddr[31:28] == PERIPH_BASE) && (daddr[27:5] == 23'd0);
        aligned = (daddr[1:0] == 2'b00);
        access  = MemRead | MemWrite;
        acc_ok  = aligned & (hit_ram | hit_per);
        acc_err = access & ~acc_ok;
        rd_only = MemRead & ~MemWrite;
        per_wr  = MemWrite & hit_per & aligned;
        off     = daddr[4:2];
    end

    assign ram_address = daddr[RAM_AW+1:2];
    assign ram_data    = ddata_w;
    assign ram_wren    = MemWrite & hit_ram & aligned;
    assign ram_wread   = rd_only & hit_ram & aligned;

    always_comb begin
        per_rdata = 32'd0;
        case (off)
            OFF_GPIO_OUT: per_rdata = 32'(gpio_q);
            OFF_GPIO_IN:  per_rdata = 32'(sync2_q);
            OFF_CNT:      per_rdata = cnt_q;
            OFF_CMP:      per_rdata = cmp_q;
            OFF_CTRL:     per_rdata = {29'd0, ctrl_q};
            OFF_STATUS:   per_rdata = {31'd0, match_q};
            default:      per_rdata = 32'd0;
        endcase
    end

    // Read select only moves on a pure read; collisions behave as writes.
    always_comb begin
        sel_d    = sel_q;
        prdata_d = prdata_q;
        if (rd_only) begin
            if (acc_err) begin
                sel_d = SEL_ZERO;
            end else if (hit_ram) begin
                sel_d = SEL_RAM;
            end else begin
                sel_d    = SEL_PERIPH;
                prdata_d = per_rdata;
            end
        end
    end

    always_comb begin
        ddata_r = 32'd0;
        case (sel_q)
            SEL_RAM:    ddata_r = ram_q;
            SEL_PERIPH: ddata_r = prdata_q;
            default:    ddata_r = 32'd0;
        endcase
    end

    assign tmr_match = ctrl_q[0] & (cnt_q == cmp_q);

    // A core write to CNT beats both increment and auto-reload; a match beats W1C.
    always_comb begin
        err_d   = err_q | acc_err;
        gpio_d  = gpio_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        if (per_wr && off == OFF_GPIO_OUT) gpio_d = ddata_w[GPIO_W-1:0];
        if (per_wr && off == OFF_CMP)      cmp_d  = ddata_w;
        if (per_wr && off == OFF_CTRL)     ctrl_d = ddata_w[2:0];
        if (per_wr && off == OFF_CNT) begin
            cnt_d = ddata_w;
        end else if (ctrl_q[0]) begin
            cnt_d = (tmr_match && ctrl_q[1]) ? 32'd0 : cnt_q + 32'd1;
        end
        if (tmr_match) begin
            match_d = 1'b1;
        end else if (per_wr && off == OFF_STATUS && ddata_w[0]) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_q    <= SEL_RAM;
            prdata_q <= 32'd0;
            err_q    <= 1'b0;
            gpio_q   <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= 32'd0;
            cmp_q    <= 32'd0;
            ctrl_q   <= 3'd0;
            match_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
            gpio_q   <= gpio_d;
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            match_q  <= match_d;
        end
    end

    assign gpio_out = gpio_q;
    assign irq      = match_q & ctrl_q[2];
    assign bus_err  = err_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Bench for mmio_bus_bridge: directed plan with literal expectations, then
// randomized traffic compared every cycle against a register-map level model.
module tb_mmio_bus_bridge;

    logic        CLK, RESET;
    logic [31:0] daddr, ddata_w, ddata_r, ram_data, ram_q;
    logic        MemRead, MemWrite, ram_wren, ram_wread, irq, bus_err;
    logic [9:0]  ram_address;
    logic [7:0]  gpio_in, gpio_out;

    int checks   = 0;
    int failures = 0;

    mmio_bus_bridge #(.RAM_AW(10), .GPIO_W(8), .PERIPH_BASE(4'h4)) dut (
        .CLK(CLK), .RESET(RESET), .daddr(daddr), .ddata_w(ddata_w),
        .MemRead(MemRead), .MemWrite(MemWrite), .ddata_r(ddata_r),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_wread(ram_wread), .ram_q(ram_q), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .irq(irq), .bus_err(bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read RAM attached to the bridge.
    logic [31:0] ram_mem [0:1023] = '{default: 32'd0};
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ram_q <= 32'd0;
        end else begin
            if (ram_wren)  ram_mem[ram_address] <= ram_data;
            if (ram_wread) ram_q <= ram_mem[ram_address];
        end
    end

    // Reference model state: the visible registers of the register map.
    logic [31:0] m_mem [0:1023] = '{default: 32'd0};
    logic [7:0]  m_gpio, m_s1, m_s2;
    logic [31:0] m_cnt, m_cmp, m_rd;
    logic [2:0]  m_ctrl;
    logic        m_match, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        logic        is_ram, is_per, al, ok, wper, hit;
        logic [2:0]  off;
        logic [31:0] pv;
        if (RESET) begin
            m_gpio = 8'd0; m_s1 = 8'd0; m_s2 = 8'd0; m_cnt = 32'd0; m_cmp = 32'd0;
            m_rd = 32'd0; m_ctrl = 3'd0; m_match = 1'b0; m_err = 1'b0;
        end
        is_ram = (daddr[31:28] == 4'h0);
        is_per = (daddr[31:28] == 4'h4) && (daddr[27:5] == 23'd0);
        al     = (daddr[1:0] == 2'b00);
        ok     = al && (is_ram || is_per);
        chk("ram_address", {22'd0, ram_address}, {22'd0, daddr[11:2]});
        chk("ram_data", ram_data, ddata_w);
        chk("ram_wren", {31'd0, ram_wren}, {31'd0, MemWrite && ok && is_ram});
        chk("ram_wread", {31'd0, ram_wread}, {31'd0, MemRead && !MemWrite && ok && is_ram});
        chk("gpio_out", {24'd0, gpio_out}, {24'd0, m_gpio});
        chk("irq", {31'd0, irq}, {31'd0, m_match && m_ctrl[2]});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
        chk("ddata_r", ddata_r, m_rd);
        if (!RESET) begin
            off = daddr[4:2];
            case (off)
                3'd0:    pv = {24'd0, m_gpio};
                3'd1:    pv = {24'd0, m_s2};
                3'd2:    pv = m_cnt;
                3'd3:    pv = m_cmp;
                3'd4:    pv = {29'd0, m_ctrl};
                3'd5:    pv = {31'd0, m_match};
                default: pv = 32'd0;
            endcase
            if (MemRead && !MemWrite) m_rd = !ok ? 32'd0 : (is_ram ? m_mem[daddr[11:2]] : pv);
            if ((MemRead || MemWrite) && !ok) m_err = 1'b1;
            if (MemWrite && ok && is_ram) m_mem[daddr[11:2]] = ddata_w;
            wper = MemWrite && ok && is_per;
            hit  = m_ctrl[0] && (m_cnt == m_cmp);
            if (wper && off == 3'd2)      m_cnt = ddata_w;
            else if (m_ctrl[0])           m_cnt = (hit && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
            if (hit)                                    m_match = 1'b1;
            else if (wper && off == 3'd5 && ddata_w[0]) m_match = 1'b0;
            if (wper && off == 3'd4) m_ctrl = ddata_w[2:0];
            if (wper && off == 3'd3) m_cmp  = ddata_w;
            if (wper && off == 3'd0) m_gpio = ddata_w[7:0];
            m_s2 = m_s1;
            m_s1 = gpio_in;
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; daddr = a; ddata_w = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Inputs change 1 time unit after a rising edge; the model checks on the falling edge.
    task automatic tick();
        @(negedge CLK);
        model_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_access(input bit allow_err);
        int cat, op;
        logic rd, wr;
        logic [31:0] a, d;
        cat = $urandom_range(0, 99);
        op  = $urandom_range(0, 9);
        rd  = (op >= 2 && op <= 5) || op == 9;
        wr  = op >= 6;
        d   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
        if (cat < 45)      a = {4'h0, 16'($urandom), 10'($urandom_range(0, 15)), 2'b00};
        else if (cat < 92) a = {4'h4, 23'd0, 3'($urandom_range(0, 7)), 2'b00};
        else if (!allow_err) begin rd = 1'b0; wr = 1'b0; a = 32'd0; end
        else begin
            case ($urandom_range(0, 3))
                0:       a = {4'h0, 26'($urandom), 2'($urandom_range(1, 3))};
                1:       a = {4'h4, 23'd0, 3'($urandom), 2'($urandom_range(1, 3))};
                2:       a = {4'h4, 23'($urandom_range(1, 8388607)), 5'($urandom) & 5'h1C};
                default: a = {4'($urandom_range(5, 15)), 26'($urandom), 2'b00};
            endcase
        end
        if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
        drive(rd, wr, a, d);
    endtask

    initial begin
        RESET = 1'b1;
        gpio_in = 8'd0;
        idle();
        #1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("rst_ddata_r", ddata_r, 32'd0);
        chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_ram_wren", {31'd0, ram_wren}, 32'd0);
        tick();

        drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        #1;
        chk("ram_wr_en", {31'd0, ram_wren}, 32'd1);
        chk("ram_wr_addr", {22'd0, ram_address}, 32'd4);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        #1;
        chk("ram_rd_en", {31'd0, ram_wread}, 32'd1);
        tick();
        idle();
        #1;
        chk("ram_rd_data", ddata_r, 32'hDEAD_BEEF);

        drive(1'b0, 1'b1, 32'h4000_0000, 32'h0000_00A5);
        tick();
        idle();
        #1;
        chk("gpio_out_wr", {24'd0, gpio_out}, 32'h0000_00A5);
        gpio_in = 8'h3C;
        tick();
        tick();
        drive(1'b1, 1'b0, 32'h4000_0004, 32'd0);
        tick();
        idle();
        #1;
        chk("gpio_in_rd", ddata_r, 32'h0000_003C);

        drive(1'b0, 1'b1, 32'h4000_000C, 32'd5);
        tick();
        drive(1'b0, 1'b1, 32'h4000_0010, 32'd7);
        tick();
        idle();
        repeat (5) tick();
        #1;
        chk("irq_before_match", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_after_match", {31'd0, irq}, 32'd1);
        drive(1'b1, 1'b0, 32'h4000_0008, 32'd0);
        tick();
        idle();
        #1;
        chk("cnt_reloaded", ddata_r, 32'd0);
        drive(1'b0, 1'b1, 32'h4000_0014, 32'd1);
        tick();
        idle();
        #1;
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        repeat (3) tick();
        drive(1'b0, 1'b1, 32'h4000_0014, 32'd1);
        tick();
        idle();
        #1;
        chk("w1c_vs_match", {31'd0, irq}, 32'd1);
        drive(1'b0, 1'b1, 32'h4000_0014, 32'd1);
        tick();
        idle();
        #1;
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        drive(1'b0, 1'b1, 32'h4000_0008, 32'h0000_0100);
        tick();
        drive(1'b1, 1'b0, 32'h4000_0008, 32'd0);
        tick();
        idle();
        #1;
        chk("cnt_write_wins", ddata_r, 32'h0000_0100);
        drive(1'b0, 1'b1, 32'h4000_0010, 32'd0);
        tick();
        idle();

        drive(1'b1, 1'b0, 32'h8000_0000, 32'd0);
        tick();
        idle();
        #1;
        chk("unmapped_err", {31'd0, bus_err}, 32'd1);
        chk("unmapped_rdata", ddata_r, 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0002, 32'h1234_5678);
        #1;
        chk("misaligned_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        idle();
        repeat (3) tick();
        chk("err_sticky", {31'd0, bus_err}, 32'd1);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("err_cleared", {31'd0, bus_err}, 32'd0);

        repeat (500) begin rand_access(1'b0); tick(); end

        // Reset lands while a RAM read is in flight.
        drive(1'b1, 1'b0, 32'h0000_0010, 32'd0);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        idle();
        #1;
        chk("rst_mid_read", ddata_r, 32'd0);
        tick();

        repeat (300) begin rand_access(1'b0); tick(); end
        repeat (300) begin rand_access(1'b1); tick(); end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
